// File: rtl/cuckoo_lookup_pipe.sv
// ============================================================================
// cuckoo_lookup_pipe : 4-stage two-candidate cuckoo hash lookup (T1/T2 -> T3).
// Optional hit counter enabled by defining CUCKOO_HIT_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cuckoo_lookup_pipe #(
   parameter int IDX_W = 10,
   parameter int PTR_W = 9,
   parameter int KEY_W = 120,
   parameter int SFX_W = 2,
   parameter int HSH   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IDX_W-1:0]       pre_hash_t1,
   input  logic [IDX_W-1:0]       pre_hash_t2,
   input  logic [7:0]             in_byte,
   input  logic [KEY_W-1:0]       in_key,
   input  logic                   stall,
   input  logic                   tbl_we,
   input  logic [1:0]             tbl_sel,
   input  logic [IDX_W-1:0]       tbl_addr,
   input  logic [KEY_W+SFX_W:0]   tbl_wdata,
   output logic                   out_valid,
   output logic [1:0]             match,
   output logic [SFX_W-1:0]       suffix
`ifdef CUCKOO_HIT_CNT_EN
   ,
   input  logic                   hit_cnt_clr,
   output logic [31:0]            hit_count
`endif
);

   localparam int ENT_W = KEY_W + SFX_W + 1;

   logic [PTR_W-1:0] r_t1 [2**IDX_W];
   logic [PTR_W-1:0] r_t2 [2**IDX_W];
   logic [ENT_W-1:0] r_t3 [2**PTR_W];

   logic             r_s1_valid, r_s2_valid, r_s3_valid;
   logic [IDX_W-1:0] r_s1_idx1, r_s1_idx2;
   logic [KEY_W-1:0] r_s1_key, r_s2_key, r_s3_key;
   logic [PTR_W-1:0] r_ptr_a, r_ptr_b;
   logic [ENT_W-1:0] r_ent_a, r_ent_b;

   logic             w_accept;
   logic [1:0]       w_hit;
   logic [SFX_W-1:0] w_sfx;

   // Sum wraps modulo 2^IDX_W because every operand is IDX_W wide.
   function automatic logic [IDX_W-1:0] hash_idx(input logic [IDX_W-1:0] p,
                                                  input logic [7:0] b);
      logic [IDX_W-1:0] sum;
      sum = (p << HSH) + (p >> HSH) + IDX_W'(b);
      return sum ^ p;
   endfunction

   assign in_ready = !stall && !tbl_we && !rst;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_hit    = '0;
      w_sfx    = '0;
      w_hit[0] = r_ent_a[ENT_W-1] && (r_ent_a[KEY_W-1:0] == r_s3_key);
      w_hit[1] = r_ent_b[ENT_W-1] && (r_ent_b[KEY_W-1:0] == r_s3_key);
      if (w_hit[0])
         w_sfx = r_ent_a[KEY_W +: SFX_W];
      else if (w_hit[1])
         w_sfx = r_ent_b[KEY_W +: SFX_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s3_valid <= 1'b0;
         out_valid  <= 1'b0;
         match      <= '0;
         suffix     <= '0;
      end else if (!stall) begin
         r_s1_valid <= w_accept;
         r_s2_valid <= r_s1_valid;
         r_s3_valid <= r_s2_valid;
         out_valid  <= r_s3_valid;
         match      <= r_s3_valid ? w_hit : 2'b00;
         suffix     <= r_s3_valid ? w_sfx : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         r_s1_idx1 <= hash_idx(pre_hash_t1, in_byte);
         r_s1_idx2 <= hash_idx(pre_hash_t2, in_byte);
         r_s1_key  <= in_key;
         r_s2_key  <= r_s1_key;
         r_s3_key  <= r_s2_key;
      end
   end

   // Table writes ignore stall; read registers hold under stall and see old data on collisions.
   always_ff @(posedge clk) begin
      if (tbl_we && tbl_sel == 2'd0)
         r_t1[tbl_addr] <= tbl_wdata[PTR_W-1:0];
      if (!stall)
         r_ptr_a <= r_t1[r_s1_idx1];
   end

   always_ff @(posedge clk) begin
      if (tbl_we && tbl_sel == 2'd1)
         r_t2[tbl_addr] <= tbl_wdata[PTR_W-1:0];
      if (!stall)
         r_ptr_b <= r_t2[r_s1_idx2];
   end

   always_ff @(posedge clk) begin
      if (tbl_we && tbl_sel == 2'd2)
         r_t3[tbl_addr[PTR_W-1:0]] <= tbl_wdata;
      if (!stall) begin
         r_ent_a <= r_t3[r_ptr_a];
         r_ent_b <= r_t3[r_ptr_b];
      end
   end

`ifdef CUCKOO_HIT_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || hit_cnt_clr)
         hit_count <= '0;
      else if (!stall && out_valid && match != 2'b00 && hit_count != 32'hFFFF_FFFF)
         hit_count <= hit_count + 32'd1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cuckoo_lookup_pipe.sv
// ============================================================================
// tb_cuckoo_lookup_pipe : directed + randomized checks against a table model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cuckoo_lookup_pipe;

   localparam int IDX_W = 10;
   localparam int PTR_W = 9;
   localparam int KEY_W = 120;
   localparam int SFX_W = 2;
   localparam int ENT_W = KEY_W + SFX_W + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IDX_W-1:0] pre_hash_t1 = '0;
   logic [IDX_W-1:0] pre_hash_t2 = '0;
   logic [7:0]       in_byte = '0;
   logic [KEY_W-1:0] in_key = '0;
   logic             stall = 1'b0;
   logic             tbl_we = 1'b0;
   logic [1:0]       tbl_sel = '0;
   logic [IDX_W-1:0] tbl_addr = '0;
   logic [ENT_W-1:0] tbl_wdata = '0;
   logic             out_valid;
   logic [1:0]       match;
   logic [SFX_W-1:0] suffix;
`ifdef CUCKOO_HIT_CNT_EN
   logic             hit_cnt_clr = 1'b0;
   logic [31:0]      hit_count;
`endif

   cuckoo_lookup_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pre_hash_t1(pre_hash_t1), .pre_hash_t2(pre_hash_t2), .in_byte(in_byte),
      .in_key(in_key), .stall(stall), .tbl_we(tbl_we), .tbl_sel(tbl_sel),
      .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .out_valid(out_valid),
      .match(match), .suffix(suffix)
`ifdef CUCKOO_HIT_CNT_EN
      , .hit_cnt_clr(hit_cnt_clr), .hit_count(hit_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int               age;
      logic [IDX_W-1:0] i1, i2;
      logic [PTR_W-1:0] pa, pb;
      logic [ENT_W-1:0] ea, eb;
      logic [KEY_W-1:0] key;
   } req_t;

   req_t             q[$];
   logic [PTR_W-1:0] m_t1 [1024];
   logic [PTR_W-1:0] m_t2 [1024];
   logic [ENT_W-1:0] m_t3 [512];
   logic [3:0]       obs_q[$];
   int               pass_cnt = 0;
   int               fail_cnt = 0;
   int               total = 0;
   int               n_out = 0;

   function automatic logic [IDX_W-1:0] ref_hash(int p, int b);
      int s;
      s = (p * 8 + p / 8 + b) % 1024;
      return IDX_W'(s ^ p);
   endfunction

   // Packed {suffix, match} that a request should produce.
   function automatic logic [3:0] outcome(req_t r);
      logic ma, mb;
      logic [1:0] sfx;
      ma  = r.ea[ENT_W-1] && (r.ea[KEY_W-1:0] == r.key);
      mb  = r.eb[ENT_W-1] && (r.eb[KEY_W-1:0] == r.key);
      sfx = ma ? r.ea[KEY_W +: SFX_W] : (mb ? r.eb[KEY_W +: SFX_W] : 2'b00);
      return {sfx, mb, ma};
   endfunction

   function automatic logic [KEY_W-1:0] rand_key();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[KEY_W-1:0];
   endfunction

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit acc;
      logic exp_v;
      logic [3:0] o;
      req_t n;
      #1;
      check("in_ready", in_ready, !stall && !tbl_we && !rst);
      @(posedge clk);
      acc = in_valid && !stall && !tbl_we && !rst;
      if (rst) begin
         q.delete();
      end else if (!stall) begin
         for (int i = 0; i < q.size(); i++) begin
            q[i].age++;
            if (q[i].age == 2) begin
               q[i].pa = m_t1[q[i].i1];
               q[i].pb = m_t2[q[i].i2];
            end else if (q[i].age == 3) begin
               q[i].ea = m_t3[q[i].pa];
               q[i].eb = m_t3[q[i].pb];
            end
         end
         if (q.size() > 0 && q[0].age > 4) void'(q.pop_front());
         if (acc) begin
            n = '{age: 1, i1: ref_hash(int'(pre_hash_t1), int'(in_byte)),
                  i2: ref_hash(int'(pre_hash_t2), int'(in_byte)),
                  pa: '0, pb: '0, ea: '0, eb: '0, key: in_key};
            q.push_back(n);
         end
      end
      if (tbl_we) begin
         case (tbl_sel)
            2'd0: m_t1[tbl_addr] = tbl_wdata[PTR_W-1:0];
            2'd1: m_t2[tbl_addr] = tbl_wdata[PTR_W-1:0];
            2'd2: m_t3[tbl_addr[PTR_W-1:0]] = tbl_wdata;
            default: ;
         endcase
      end
      @(negedge clk);
      exp_v = (q.size() > 0) && (q[0].age == 4);
      o = exp_v ? outcome(q[0]) : 4'b0000;
      check("out_valid", out_valid, exp_v);
      check("match", match, o[1:0]);
      check("suffix", suffix, o[3:2]);
      if (out_valid) begin
         n_out++;
         obs_q.push_back({suffix, match});
      end
   endtask

   task automatic wr(input logic [1:0] sel, input int addr, input logic [ENT_W-1:0] data);
      tbl_we = 1'b1;
      tbl_sel = sel;
      tbl_addr = IDX_W'(addr);
      tbl_wdata = data;
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic set_req(input int p1, input int p2, input int b, input logic [KEY_W-1:0] k);
      in_valid = 1'b1;
      pre_hash_t1 = IDX_W'(p1);
      pre_hash_t2 = IDX_W'(p2);
      in_byte = 8'(b);
      in_key = k;
   endtask

   task automatic lookup_expect(string tag, input int p1, input int p2, input int b,
                                input logic [KEY_W-1:0] k, input logic [3:0] exp);
      set_req(p1, p2, b, k);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_match"}, match, exp[1:0]);
      check({tag, "_suffix"}, suffix, exp[3:2]);
      tick();
   endtask

   initial begin
      logic [KEY_W-1:0] ka, kb, kc, kr;
      logic [IDX_W-1:0] ri1, ri2;
      int p1, p2, b;

      repeat (2) tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_match", match, 2'b00);
      check("rst_suffix", suffix, 2'b00);
      rst = 1'b0;

      for (int i = 0; i < 1024; i++) wr(2'd0, i, ENT_W'($urandom_range(511)));
      for (int i = 0; i < 1024; i++) wr(2'd1, i, ENT_W'($urandom_range(511)));
      for (int i = 0; i < 512; i++) wr(2'd2, i, {1'($urandom), 2'($urandom), rand_key()});

      // Basic hit on path A; path B points at an invalid entry.
      ka = rand_key(); kb = rand_key(); kc = rand_key();
      wr(2'd0, 'h041, ENT_W'(5));
      wr(2'd1, 'h041, ENT_W'(6));
      wr(2'd2, 5, {1'b1, 2'b10, ka});
      wr(2'd2, 6, '0);
      lookup_expect("basic", 0, 0, 'h41, ka, 4'b1001);

      // Wrap: pre_hash_t2=0x3FF, byte 0 must land on T2[0x388].
      wr(2'd0, 0, ENT_W'(6));
      wr(2'd1, 'h388, ENT_W'(7));
      wr(2'd2, 7, {1'b1, 2'b11, kb});
      lookup_expect("wrap", 0, 'h3FF, 0, kb, 4'b1110);

      // Double hit: A's suffix wins.
      wr(2'd0, 0, ENT_W'(8));
      wr(2'd1, 'h388, ENT_W'(9));
      wr(2'd2, 8, {1'b1, 2'b01, kc});
      wr(2'd2, 9, {1'b1, 2'b11, kc});
      lookup_expect("double", 0, 'h3FF, 0, kc, 4'b0111);

      // Stall for 5 cycles after the second of three back-to-back requests.
      n_out = 0; obs_q.delete();
      set_req(0, 0, 'h41, ka); tick();
      set_req(0, 'h3FF, 0, kc); tick();
      stall = 1'b1;
      set_req(0, 'h3FF, 0, kb);
      repeat (5) tick();
      stall = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      check("stall_pulses", n_out, 3);
      if (obs_q.size() == 3) begin
         check("stall_res0", obs_q[0], 4'b1001);
         check("stall_res1", obs_q[1], 4'b0111);
         check("stall_res2", obs_q[2], 4'b0000);
      end

      // Reset two cycles after acceptance drops the request; tables survive.
      set_req(0, 0, 'h41, ka); tick();
      in_valid = 1'b0; tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      n_out = 0;
      repeat (5) tick();
      check("rst_no_out", n_out, 0);
      lookup_expect("after_rst", 0, 0, 'h41, ka, 4'b1001);

      // A write cycle blocks a request.
      set_req(0, 0, 'h41, ka);
      tbl_we = 1'b1; tbl_sel = 2'd3;
      #1 check("we_in_ready", in_ready, 1'b0);
      tick();
      tbl_we = 1'b0; in_valid = 1'b0;
      n_out = 0;
      repeat (6) tick();
      check("we_no_accept", n_out, 0);

      // Overwrite T3[5] on the same edge the lookup reads it: old entry wins.
      set_req(0, 0, 'h41, ka); tick();
      in_valid = 1'b0; tick();
      wr(2'd2, 5, {1'b1, 2'b01, ka});
      tick();
      check("rdfirst_match", match, 2'b01);
      check("rdfirst_suffix", suffix, 2'b10);
      tick();
      lookup_expect("new_entry", 0, 0, 'h41, ka, 4'b0101);

      // Randomized traffic with stalls, writes and rare resets.
      for (int c = 0; c < 400; c++) begin
         p1 = int'($urandom_range(1023));
         p2 = int'($urandom_range(1023));
         b  = int'($urandom_range(255));
         ri1 = ref_hash(p1, b);
         ri2 = ref_hash(p2, b);
         case ($urandom_range(2))
            0: kr = m_t3[m_t1[ri1]][KEY_W-1:0];
            1: kr = m_t3[m_t2[ri2]][KEY_W-1:0];
            default: kr = rand_key();
         endcase
         set_req(p1, p2, b, kr);
         in_valid = 1'($urandom);
         stall = ($urandom_range(4) == 0);
         rst = ($urandom_range(99) == 0);
         tbl_we = ($urandom_range(9) == 0);
         tbl_sel = 2'($urandom);
         tbl_addr = IDX_W'($urandom);
         tbl_wdata = {1'($urandom), 2'($urandom), kr};
         tick();
      end
      in_valid = 1'b0; stall = 1'b0; rst = 1'b0; tbl_we = 1'b0;
      repeat (8) tick();

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cuckoo_lookup_pipe.md
CUCKOO_LOOKUP_PIPE -- requirements
Module: cuckoo_lookup_pipe

Interface
REQ-001 SHALL have parameter IDX_W, default 10: hash index width; T1 and T2 each hold 2^IDX_W entries.
REQ-002 SHALL have parameter PTR_W, default 9: entry-table pointer width; T3 holds 2^PTR_W entries.
REQ-003 SHALL have parameter KEY_W, default 120: compared key width.
REQ-004 SHALL have parameter SFX_W, default 2: suffix field width.
REQ-005 SHALL have parameter HSH, default 3: hash shift amount.
REQ-006 SHALL define localparam ENT_W = KEY_W+SFX_W+1; a T3 entry is {valid, suffix, key}, with the MSB as valid.
REQ-007 SHALL have port clk, input, 1 bit: the only clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port in_valid, input, 1 bit: lookup request.
REQ-010 SHALL have port in_ready, output, 1 bit: request accepted this cycle.
REQ-011 SHALL have ports pre_hash_t1 and pre_hash_t2, input, IDX_W bits each: pre-hash values.
REQ-012 SHALL have port in_byte, input, 8 bits: current payload byte.
REQ-013 SHALL have port in_key, input, KEY_W bits: key to compare.
REQ-014 SHALL have port stall, input, 1 bit: freezes the entire pipeline.
REQ-015 SHALL have port tbl_we, input, 1 bit: table write strobe.
REQ-016 SHALL have port tbl_sel, input, 2 bits: table select; 0=T1, 1=T2, 2=T3, 3=ignored.
REQ-017 SHALL have port tbl_addr, input, IDX_W bits: write address; T3 uses the low PTR_W bits.
REQ-018 SHALL have port tbl_wdata, input, ENT_W bits: write data; T1 and T2 use the low PTR_W bits.
REQ-019 SHALL have port out_valid, output, 1 bit: result valid.
REQ-020 SHALL have port match, output, 2 bits: bit0 = candidate A hit, bit1 = candidate B hit.
REQ-021 SHALL have port suffix, output, SFX_W bits: suffix of the winning entry.

Function
REQ-022 SHALL drive in_ready = !stall && !tbl_we; a request is accepted when in_valid && in_ready.
REQ-023 SHALL compute, in stage 1, idxN = (((pre_hash_tN << HSH) + (pre_hash_tN >> HSH) + in_byte) mod 2^IDX_W) ^ pre_hash_tN, for N = 1, 2.
- Stage 1 also registers in_key and a valid bit.
REQ-024 SHALL, in stage 2, read T1[idx1] to give ptrA and T2[idx2] to give ptrB, as registered block-RAM reads.
REQ-025 SHALL, in stage 3, read T3[ptrA] to give entA and T3[ptrB] to give entB, using a dual-port registered read.
REQ-026 SHALL, in stage 4, register the result:
- match[0] = entA.valid && entA.key == key.
- match[1] = entB.valid && entB.key == key.
REQ-027 SHALL set suffix = entA.suffix if match[0], else entB.suffix if match[1], else 0; A wins when both hit.
REQ-028 SHALL carry the key and valid bit through every stage, so each result is aligned with its own request.
REQ-029 SHALL give a latency of exactly 4 unstalled cycles from acceptance to out_valid=1.
- With no stalls, out_valid is a single-cycle pulse per request.
- Back-to-back requests give one result per cycle.
REQ-030 SHALL, while stall=1, hold all stage registers, RAM output registers and outputs.
- No bubble is inserted and no result is lost or duplicated.
REQ-031 SHALL, when out_valid=0, drive match=0 and suffix=0.
REQ-032 SHALL perform a table write on any cycle with tbl_we=1, including cycles with stall=1.
REQ-033 SHALL let in-flight lookups continue during a write (subject to stall).
REQ-034 SHALL use read-first behaviour: a read of the address being written returns the old data.
REQ-035 SHALL discard the upper bits implicitly in all hash arithmetic; wrap modulo 2^IDX_W is required.

Reset
REQ-036 SHALL, on rst=1 at a clk edge, clear all stage valid bits.
- out_valid=0, match=0, suffix=0 and hit_count=0 on the following cycle.
REQ-037 SHALL discard in-flight lookups when rst is asserted mid-operation; no result appears for them.
REQ-038 SHALL NOT clear table contents on rst; tables retain loaded data.
REQ-039 SHALL hold in_ready=0 while rst=1.

Configuration
REQ-040 SHALL, when CUCKOO_HIT_CNT_EN is defined, add the following ports:
- hit_cnt_clr, input, 1 bit.
- hit_count, output, 32 bits.
REQ-041 SHALL, with CUCKOO_HIT_CNT_EN defined, increment hit_count on each unstalled cycle where out_valid && match!=0.
- The count saturates at 0xFFFFFFFF.
- hit_cnt_clr has priority over increment and zeroes the count next cycle.
REQ-042 SHALL, when CUCKOO_HIT_CNT_EN is not defined, have neither port nor counter logic.

Verification
REQ-043 SHALL cover basic hit:
- Stimulus: T1[0x041]=5; T3[5]={1,2'b10,K}; pre_hash_t1=0, in_byte=0x41, in_key=K; path B misses.
- Required response: 4 cycles later out_valid=1, match=2'b01, suffix=2'b10.
REQ-044 SHALL cover wrap:
- Stimulus: pre_hash_t2=0x3FF, in_byte=0.
- Required response: T2 is read at index 0x388; with T2[0x388]=7 and T3[7] matching, match=2'b10.
REQ-045 SHALL cover double hit:
- Stimulus: both paths match; entA.suffix=1, entB.suffix=3.
- Required response: match=2'b11, suffix=1.
REQ-046 SHALL cover stall:
- Stimulus: 3 back-to-back requests; stall=1 for 5 cycles after the 2nd is accepted.
- Required response: exactly 3 out_valid pulses, in order, each with its correct result.
REQ-047 SHALL cover mid-flight reset:
- Stimulus: rst pulse 2 cycles after a request is accepted.
- Required response: no out_valid for that request; table contents unchanged; a subsequent lookup still hits.
REQ-048 SHALL cover write/read-first:
- Stimulus: tbl_we with in_valid=1 in the same cycle.
- Required response: in_ready=0 and the request is not accepted.
- Stimulus: a write to T3[5] while a lookup is reading T3[5].
- Required response: the lookup returns the old entry.
